// File: rtl/pcie_pkg.sv
// rtl/pcie_pkg.sv - shared PCIe ingress types: TLP header, register offset map codes, direction constants
// Also provides fallback values for the `PCIE_DATA_WIDTH / `PCIE_DATA_KW build macros.
`ifndef PCIE_DATA_WIDTH
`define PCIE_DATA_WIDTH 128
`endif
`ifndef PCIE_DATA_KW
`define PCIE_DATA_KW (`PCIE_DATA_WIDTH/8)
`endif

package pcie_pkg;

  // Memory-write TLP header as delivered by the ingress pre-parser.
  typedef struct packed {
    logic [9:0] length;   // payload length in DWs
    logic [3:0] offset;   // starting register offset
    logic [3:0] channel;  // target channel
  } tlp_head_t;

  // Register offsets within a channel window; 8..15 are unmapped.
  typedef enum logic [3:0] {
    OFF_RX_SG_LEN      = 4'd0,
    OFF_RX_SG_ADDR_LO  = 4'd1,
    OFF_RX_SG_ADDR_HI  = 4'd2,
    OFF_RX_XFER_LEN    = 4'd3,
    OFF_RX_OFFSET_LAST = 4'd4,
    OFF_TX_SG_LEN      = 4'd5,
    OFF_TX_SG_ADDR_LO  = 4'd6,
    OFF_TX_SG_ADDR_HI  = 4'd7
  } wr_offset_e;

  // Register codes inside a TX/RX action register bank.
  typedef enum logic [2:0] {
    REG_XFER_LEN    = 3'b000,
    REG_OFFSET_LAST = 3'b001,
    REG_SG_LEN      = 3'b011,
    REG_SG_ADDR_LO  = 3'b100,
    REG_SG_ADDR_HI  = 3'b101
  } reg_code_e;

  localparam logic [1:0] DIR_TX = 2'b00;
  localparam logic [1:0] DIR_RX = 2'b01;

  // First offset that has no register behind it; bursts truncate below it.
  localparam logic [3:0] FIRST_UNMAPPED_OFF = 4'd8;

endpackage

// File: rtl/ingress_wrreq_decode.sv
// rtl/ingress_wrreq_decode.sv - combinational register offset to {reg, dir, mapped} lookup
// Ports:
//   offset   in   4  register offset within the channel window
//   reg_code out  3  register code in the action bank
//   dir      out  2  bank direction (DIR_TX / DIR_RX)
//   mapped   out  1  offset has a register behind it
module ingress_wrreq_decode
  import pcie_pkg::*;
(
  input  logic [3:0] offset,
  output reg_code_e  reg_code,
  output logic [1:0] dir,
  output logic       mapped
);

  always_comb begin
    reg_code = REG_XFER_LEN;
    dir      = DIR_TX;
    mapped   = 1'b1;
    case (offset)
      OFF_RX_SG_LEN:      begin reg_code = REG_SG_LEN;      dir = DIR_RX; end
      OFF_RX_SG_ADDR_LO:  begin reg_code = REG_SG_ADDR_LO;  dir = DIR_RX; end
      OFF_RX_SG_ADDR_HI:  begin reg_code = REG_SG_ADDR_HI;  dir = DIR_RX; end
      OFF_RX_XFER_LEN:    begin reg_code = REG_XFER_LEN;    dir = DIR_RX; end
      OFF_RX_OFFSET_LAST: begin reg_code = REG_OFFSET_LAST; dir = DIR_RX; end
      OFF_TX_SG_LEN:      begin reg_code = REG_SG_LEN;      dir = DIR_TX; end
      OFF_TX_SG_ADDR_LO:  begin reg_code = REG_SG_ADDR_LO;  dir = DIR_TX; end
      OFF_TX_SG_ADDR_HI:  begin reg_code = REG_SG_ADDR_HI;  dir = DIR_TX; end
      default:            mapped = 1'b0;
    endcase
  end

endmodule

// File: rtl/ingress_wrreq_dispatch.sv
// rtl/ingress_wrreq_dispatch.sv - splits memory-write TLP beats into per-DW channel register writes
// Optional feature macro: WRREQ_ERR_CNT_EN (adds err_cnt port and saturating drop counter).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wrreq_data/keep     ingress beat payload (DW0 in [31:0]) and byte enables (unused for decode)
//   wrreq_meta          TLP header (channel, offset, length)
//   wrreq_valid/rdy     ingress beat handshake
//   wr_valid/rdy        register write handshake
//   wr_tdest            {reg[2:0], dir[1:0], channel[CH_W-1:0]}
//   wr_tdata            register write data
//   wr_err              one-cycle pulse per dropped or truncated TLP
//   err_cnt             saturating wr_err count (WRREQ_ERR_CNT_EN only)
module ingress_wrreq_dispatch
  import pcie_pkg::*;
#(
  parameter int NUM_CHANNELS = 12,
  parameter int DATA_W       = `PCIE_DATA_WIDTH,
  parameter int ERR_CNT_W    = 16,
  localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        wrreq_data,
  input  logic [`PCIE_DATA_KW-1:0] wrreq_keep,
  input  tlp_head_t                wrreq_meta,
  input  logic                     wrreq_valid,
  output logic                     wrreq_rdy,
  output logic                     wr_valid,
  input  logic                     wr_rdy,
  output logic [CH_W+4:0]          wr_tdest,
  output logic [31:0]              wr_tdata,
  output logic                     wr_err
`ifdef WRREQ_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]     err_cnt
`endif
);

  localparam int DWS = DATA_W / 32;

  typedef enum logic {S_IDLE, S_EMIT} state_e;

  typedef struct packed {
    reg_code_e       rg;
    logic [1:0]      dir;
    logic [CH_W-1:0] ch;
  } wr_tdest_t;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] beat_q;
  logic [CH_W-1:0]   ch_q;
  logic [3:0]        off_q;   // offset of the DW currently presented
  logic [3:0]        idx_q;   // beat index of the next DW to present
  logic [3:0]        cnt_q;   // DWs still to present after the current one
  wr_tdest_t         tdest_q, tdest_nxt;

  logic       accept, drop, trunc, last_dw;
  logic       chan_bad, len_bad;
  logic [3:0] dec_off, room, n_eff;
  logic [CH_W-1:0] ch_nxt;
  logic [31:0] dw_sel;
  reg_code_e  dec_reg;
  logic [1:0] dec_dir;
  logic       dec_mapped;
  logic       unused_keep;

  assign unused_keep = ^wrreq_keep;

  assign last_dw   = (cnt_q == 4'd0);
  assign wrreq_rdy = (state_q == S_IDLE) || (last_dw && wr_rdy);
  assign accept    = wrreq_valid && wrreq_rdy;

  // One decoder serves both the start offset of a new TLP and the next
  // offset of a running burst; a new accept always takes priority.
  assign dec_off = accept ? wrreq_meta.offset : off_q + 4'd1;

  ingress_wrreq_decode u_decode (
    .offset   (dec_off),
    .reg_code (dec_reg),
    .dir      (dec_dir),
    .mapped   (dec_mapped)
  );

  assign chan_bad = 32'(wrreq_meta.channel) >= NUM_CHANNELS;
  assign len_bad  = (wrreq_meta.length == 10'd0) || (32'(wrreq_meta.length) > DWS);
  assign drop     = chan_bad || len_bad || !dec_mapped;

  // DWs that fit before the unmapped region; longer bursts are cut there.
  assign room  = FIRST_UNMAPPED_OFF - wrreq_meta.offset;
  assign trunc = wrreq_meta.length > {6'd0, room};
  assign n_eff = trunc ? room : wrreq_meta.length[3:0];

  assign dw_sel    = 32'(beat_q >> {idx_q, 5'b00000});
  assign ch_nxt    = accept ? CH_W'(wrreq_meta.channel) : ch_q;
  assign tdest_nxt = '{rg: dec_reg, dir: dec_dir, ch: ch_nxt};
  assign wr_tdest  = tdest_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept)                                   state_d = drop ? S_IDLE : S_EMIT;
    else if (state_q == S_EMIT && wr_rdy && last_dw) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid <= 1'b0;
      tdest_q  <= '0;
      wr_tdata <= '0;
      wr_err   <= 1'b0;
      beat_q   <= '0;
      ch_q     <= '0;
      off_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      wr_err <= accept && (drop || trunc);
      if (accept && !drop) begin
        wr_valid <= 1'b1;
        tdest_q  <= tdest_nxt;
        wr_tdata <= wrreq_data[31:0];
        beat_q   <= wrreq_data;
        ch_q     <= ch_nxt;
        off_q    <= wrreq_meta.offset;
        idx_q    <= 4'd1;
        cnt_q    <= n_eff - 4'd1;
      end else if (wr_valid && wr_rdy) begin
        if (last_dw) begin
          wr_valid <= 1'b0;
        end else begin
          tdest_q  <= tdest_nxt;
          wr_tdata <= dw_sel;
          off_q    <= off_q + 4'd1;
          idx_q    <= idx_q + 4'd1;
          cnt_q    <= cnt_q - 4'd1;
        end
      end
    end
  end

`ifdef WRREQ_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (accept && (drop || trunc) && !(&err_cnt))
      err_cnt <= err_cnt + ERR_CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_ingress_wrreq_dispatch.sv
// tb/tb_ingress_wrreq_dispatch.sv - table-driven bench for ingress_wrreq_dispatch
`ifndef PCIE_DATA_WIDTH
`define PCIE_DATA_WIDTH 128
`endif
`ifndef PCIE_DATA_KW
`define PCIE_DATA_KW (`PCIE_DATA_WIDTH/8)
`endif

module tb_ingress_wrreq_dispatch;
  import pcie_pkg::*;

  logic                     clk;
  logic                     rst_n;
  logic [127:0]             wrreq_data;
  logic [`PCIE_DATA_KW-1:0] wrreq_keep;
  tlp_head_t                wrreq_meta;
  logic                     wrreq_valid;
  logic                     wrreq_rdy;
  logic                     wr_valid;
  logic                     wr_rdy;
  logic [8:0]               wr_tdest;
  logic [31:0]              wr_tdata;
  logic                     wr_err;
`ifdef WRREQ_ERR_CNT_EN
  logic [15:0]              err_cnt;
`endif

  ingress_wrreq_dispatch #(
    .NUM_CHANNELS (12),
    .DATA_W       (128),
    .ERR_CNT_W    (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wrreq_data  (wrreq_data),
    .wrreq_keep  (wrreq_keep),
    .wrreq_meta  (wrreq_meta),
    .wrreq_valid (wrreq_valid),
    .wrreq_rdy   (wrreq_rdy),
    .wr_valid    (wr_valid),
    .wr_rdy      (wr_rdy),
    .wr_tdest    (wr_tdest),
    .wr_tdata    (wr_tdata),
    .wr_err      (wr_err)
`ifdef WRREQ_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       ch;
    logic [3:0]       off;
    logic [9:0]       len;
    logic [3:0][31:0] d;
    int               n;      // expected register writes
    int               err;    // expected wr_err pulses
    logic [3:0][8:0]  td;     // expected tdest per write
  } vec_t;

  vec_t vecs[13];
  int   nvec  = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] ch, input logic [3:0] off, input logic [9:0] len,
                     input logic [31:0] d0, input int n, input int err,
                     input logic [8:0] t0, input logic [8:0] t1,
                     input logic [8:0] t2, input logic [8:0] t3);
    vec_t v;
    v.ch  = ch;
    v.off = off;
    v.len = len;
    for (int k = 0; k < 4; k++) v.d[k] = d0 + k * 32'h0101_0101;
    v.n   = n;
    v.err = err;
    v.td[0] = t0; v.td[1] = t1; v.td[2] = t2; v.td[3] = t3;
    vecs[nvec] = v;
    nvec++;
  endtask

  task automatic drive_tlp(input logic [3:0] ch, input logic [3:0] off, input logic [9:0] len,
                           input logic [127:0] data);
    wrreq_meta.channel = ch;
    wrreq_meta.offset  = off;
    wrreq_meta.length  = len;
    wrreq_data         = data;
    wrreq_valid        = 1'b1;
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    logic [8:0]  got_td[8];
    logic [31:0] got_d[8];
    int          nw, ne, nlow;
    logic        first_v, first_e;
    v    = vecs[i];
    nw   = 0;
    ne   = 0;
    nlow = 0;
    @(negedge clk);
    wr_rdy = 1'b1;
    drive_tlp(v.ch, v.off, v.len, v.d);
    #1;
    check($sformatf("v%0d_rdy_idle", i), wrreq_rdy, 1);
    @(posedge clk); #1;
    wrreq_valid = 1'b0;
    first_v = wr_valid;
    first_e = wr_err;
    for (int s = 0; s < 10; s++) begin
      if (wr_valid) begin
        if (nw < 8) begin
          got_td[nw] = wr_tdest;
          got_d[nw]  = wr_tdata;
        end
        nw++;
      end
      if (wr_err)     ne++;
      if (!wrreq_rdy) nlow++;
      @(posedge clk); #1;
    end
    check($sformatf("v%0d_first_valid", i), first_v, (v.n > 0) ? 1 : 0);
    check($sformatf("v%0d_first_err", i), first_e, v.err);
    check($sformatf("v%0d_nwrites", i), nw, v.n);
    check($sformatf("v%0d_nerr", i), ne, v.err);
    check($sformatf("v%0d_rdy_low", i), nlow, (v.n > 1) ? v.n - 1 : 0);
    for (int k = 0; k < v.n && k < nw && k < 4; k++) begin
      check($sformatf("v%0d_td%0d", i, k), got_td[k], v.td[k]);
      check($sformatf("v%0d_d%0d", i, k), got_d[k], v.d[k]);
    end
  endtask

  initial begin
    logic [8:0]  bp_td[4];
    logic [31:0] bp_d[4];
    logic [41:0] hold;
    logic [127:0] da, db;
    int          nw;

    rst_n       = 1'b0;
    wrreq_data  = '0;
    wrreq_keep  = '1;
    wrreq_meta  = '0;
    wrreq_valid = 1'b0;
    wr_rdy      = 1'b1;

    //    ch     off    len    d0             n  err  tdest list {reg,dir,ch}
    add(4'd3,  4'd1,  10'd1, 32'hDEADBEEF, 1, 0, 9'b100_01_0011, 9'h0, 9'h0, 9'h0);
    add(4'd0,  4'd5,  10'd3, 32'h0000000A, 3, 0, 9'b011_00_0000, 9'b100_00_0000, 9'b101_00_0000, 9'h0);
    add(4'd13, 4'd1,  10'd1, 32'h11111111, 0, 1, 9'h0, 9'h0, 9'h0, 9'h0);
    add(4'd1,  4'd9,  10'd1, 32'h22222222, 0, 1, 9'h0, 9'h0, 9'h0, 9'h0);
    add(4'd1,  4'd0,  10'd0, 32'h33333333, 0, 1, 9'h0, 9'h0, 9'h0, 9'h0);
    add(4'd1,  4'd0,  10'd5, 32'h44444444, 0, 1, 9'h0, 9'h0, 9'h0, 9'h0);
    add(4'd2,  4'd6,  10'd4, 32'h55550000, 2, 1, 9'b100_00_0010, 9'b101_00_0010, 9'h0, 9'h0);
    add(4'd11, 4'd3,  10'd4, 32'h66660000, 4, 0, 9'b000_01_1011, 9'b001_01_1011, 9'b011_00_1011, 9'b100_00_1011);
    add(4'd12, 4'd0,  10'd1, 32'h77777777, 0, 1, 9'h0, 9'h0, 9'h0, 9'h0);
    add(4'd5,  4'd7,  10'd1, 32'h88880000, 1, 0, 9'b101_00_0101, 9'h0, 9'h0, 9'h0);
    add(4'd4,  4'd7,  10'd2, 32'h99990000, 1, 1, 9'b101_00_0100, 9'h0, 9'h0, 9'h0);
    add(4'd10, 4'd2,  10'd2, 32'hAAAA0000, 2, 0, 9'b101_01_1010, 9'b000_01_1010, 9'h0, 9'h0);
    add(4'd0,  4'd0,  10'd4, 32'hBBBB0000, 4, 0, 9'b011_01_0000, 9'b100_01_0000, 9'b101_01_0000, 9'b000_01_0000);

    // Reset state
    #12;
    check("reset_outputs", {wr_valid, wr_tdest, wr_tdata, wr_err}, 42'd0);
`ifdef WRREQ_ERR_CNT_EN
    check("reset_err_cnt", err_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rdy_after_reset", wrreq_rdy, 1);

    for (int i = 0; i < nvec; i++) run_vec(i);

`ifdef WRREQ_ERR_CNT_EN
    check("err_cnt_total", err_cnt, 7);
`endif

    // Backpressure: wr_rdy low for 5 cycles after the first DW handshakes
    @(negedge clk);
    wr_rdy = 1'b1;
    drive_tlp(4'd1, 4'd3, 10'd4, {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0});
    @(posedge clk); #1;
    wrreq_valid = 1'b0;
    nw   = 0;
    hold = '0;
    for (int s = 0; s < 14; s++) begin
      wr_rdy = !(s >= 1 && s <= 5);
      if (s == 1) hold = {wr_valid, wr_tdest, wr_tdata};
      if (s >= 2 && s <= 6)
        check($sformatf("bp_hold_s%0d", s), {wr_valid, wr_tdest, wr_tdata}, hold);
      if (wr_valid && wr_rdy) begin
        if (nw < 4) begin
          bp_td[nw] = wr_tdest;
          bp_d[nw]  = wr_tdata;
        end
        nw++;
      end
      @(posedge clk); #1;
    end
    wr_rdy = 1'b1;
    check("bp_nwrites", nw, 4);
    if (nw >= 4) begin
      check("bp_td0", bp_td[0], 9'b000_01_0001);
      check("bp_td1", bp_td[1], 9'b001_01_0001);
      check("bp_td2", bp_td[2], 9'b011_00_0001);
      check("bp_td3", bp_td[3], 9'b100_00_0001);
      check("bp_d0", bp_d[0], 32'hA0A0A0A0);
      check("bp_d1", bp_d[1], 32'hB1B1B1B1);
      check("bp_d2", bp_d[2], 32'hC2C2C2C2);
      check("bp_d3", bp_d[3], 32'hD3D3D3D3);
    end

    // Back-to-back TLPs: second accepted on the first's last-DW cycle
    da = {32'h0, 32'h0, 32'h12340002, 32'h12340001};
    db = {32'h0, 32'h0, 32'h0, 32'h56780001};
    @(negedge clk);
    drive_tlp(4'd0, 4'd5, 10'd2, da);
    @(posedge clk); #1;
    check("b2b_s1", {wr_valid, wr_tdest, wr_tdata}, {1'b1, 9'b011_00_0000, 32'h12340001});
    check("b2b_s1_rdy", wrreq_rdy, 0);
    drive_tlp(4'd2, 4'd0, 10'd1, db);
    @(posedge clk); #1;
    check("b2b_s2", {wr_valid, wr_tdest, wr_tdata}, {1'b1, 9'b100_00_0000, 32'h12340002});
    wr_rdy = 1'b0;
    #1;
    check("b2b_rdy_comb_low", wrreq_rdy, 0);
    wr_rdy = 1'b1;
    #1;
    check("b2b_rdy_comb_high", wrreq_rdy, 1);
    @(posedge clk); #1;
    wrreq_valid = 1'b0;
    check("b2b_s3", {wr_valid, wr_tdest, wr_tdata}, {1'b1, 9'b011_01_0010, 32'h56780001});
    @(posedge clk); #1;
    check("b2b_s4_idle", wr_valid, 0);

    // Reset in the middle of a burst
    @(negedge clk);
    drive_tlp(4'd0, 4'd5, 10'd3, {32'h0, 32'h3, 32'h2, 32'h1});
    @(posedge clk); #1;
    wrreq_valid = 1'b0;
    check("rst_burst_started", wr_valid, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {wr_valid, wr_tdest, wr_tdata, wr_err}, 42'd0);
    check("rst_mid_rdy", wrreq_rdy, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nw = 0;
    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #1;
      if (wr_valid) nw++;
    end
    check("rst_no_resume", nw, 0);
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
